// File: rtl/dff_variants_pkg.sv
// Shared defaults and data type for the dff_variants register library.
package dff_variants_pkg;
  localparam int   DFF_WIDTH_DEF   = 1;
  localparam logic DFF_RST_BIT_DEF = 1'b0;

  typedef logic [DFF_WIDTH_DEF-1:0] data_t;
endpackage

// File: rtl/dff_core.sv
// Single edge-triggered register with optional clock enable and sync reset.
// Latency 1 cycle; no backpressure (enable only gates the load).
module dff_core #(
  parameter int               WIDTH   = 1,
  parameter bit               HAS_EN  = 1'b0,
  parameter bit               HAS_RST = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Reset outranks enable; absent features collapse to constants.
  always_comb begin
    q_d = q_q;
    if (HAS_RST && rst) begin
      q_d = RST_VAL;
    end else if (!HAS_EN || en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/dff_variants.sv
// Plain, enable and enable+sync-reset DFFs side by side; latency 1 cycle, no backpressure.
// DFF_VARIANTS_QN_EN adds complemented outputs qn/qen/qern taken from the same flops.
module dff_variants
  import dff_variants_pkg::*;
#(
  parameter int               WIDTH   = DFF_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DFF_RST_BIT_DEF}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qe,
  output logic [WIDTH-1:0] qer
`ifdef DFF_VARIANTS_QN_EN
  ,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] qen,
  output logic [WIDTH-1:0] qern
`endif
);
  dff_core #(.WIDTH(WIDTH), .HAS_EN(1'b0), .HAS_RST(1'b0), .RST_VAL(RST_VAL)) u_plain (
    .clk(clk), .rst(rst), .en(en), .d(d), .q(q)
  );

  dff_core #(.WIDTH(WIDTH), .HAS_EN(1'b1), .HAS_RST(1'b0), .RST_VAL(RST_VAL)) u_en (
    .clk(clk), .rst(rst), .en(en), .d(d), .q(qe)
  );

  dff_core #(.WIDTH(WIDTH), .HAS_EN(1'b1), .HAS_RST(1'b1), .RST_VAL(RST_VAL)) u_en_rst (
    .clk(clk), .rst(rst), .en(en), .d(d), .q(qer)
  );

`ifdef DFF_VARIANTS_QN_EN
  assign qn   = ~q;
  assign qen  = ~qe;
  assign qern = ~qer;
`endif
endmodule

// File: tb/tb_dff_variants.sv
// Directed and random checks of dff_variants against a value-tracking reference model.
module tb_dff_variants;
  localparam int         W    = 4;
  localparam logic [3:0] RSTV = 4'hA;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic [W-1:0] d   = '0;
  logic [W-1:0] q, qe, qer;
`ifdef DFF_VARIANTS_QN_EN
  logic [W-1:0] qn, qen, qern;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: last value each output was told to hold, plus whether it is defined yet.
  logic [W-1:0] exp_q, exp_qe, exp_qer;
  bit           q_known = 0, qe_known = 0, qer_known = 0;

  dff_variants #(.WIDTH(W), .RST_VAL(RSTV)) dut (
    .clk(clk), .rst(rst), .d(d), .en(en), .q(q), .qe(qe), .qer(qer)
`ifdef DFF_VARIANTS_QN_EN
    , .qn(qn), .qen(qen), .qern(qern)
`endif
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge: apply inputs, optionally glitch them mid-cycle,
  // let one rising edge happen, then compare at the next falling edge.
  task automatic cycle(input logic [W-1:0] dv, input logic env, input logic rstv, input bit glitch);
    d = dv; en = env; rst = rstv;
    if (glitch) begin
      #3;
      rst = 1'b1; en = ~env; d = ~dv;
      #2;
      rst = rstv; en = env; d = dv;
    end
    @(posedge clk);
    exp_q = dv; q_known = 1;
    if (env) begin exp_qe = dv; qe_known = 1; end
    if (rstv) begin exp_qer = RSTV; qer_known = 1; end
    else if (env) begin exp_qer = dv; qer_known = 1; end
    @(negedge clk);
    if (q_known) chk("q", q, exp_q);
    if (qe_known) chk("qe", qe, exp_qe);
    if (qer_known) chk("qer", qer, exp_qer);
`ifdef DFF_VARIANTS_QN_EN
    if (q_known) chk("qn", qn, ~exp_q);
    if (qe_known) chk("qen", qen, ~exp_qe);
    if (qer_known) chk("qern", qern, ~exp_qer);
`endif
  endtask

  initial begin
    // Plain register loads while enable register stays undefined.
    cycle(4'h1, 1'b0, 1'b0, 0);
    cycle(4'h0, 1'b1, 1'b0, 0);
    // Enable hold with inputs wiggling between edges.
    cycle(4'h1, 1'b0, 1'b0, 1);
    // Reset together with enable: reset wins.
    cycle(4'h3, 1'b1, 1'b1, 0);
    // Reset pulses that miss every edge must not clear qer.
    cycle(4'h5, 1'b1, 1'b0, 1);
    cycle(4'h1, 1'b0, 1'b0, 1);
    cycle(4'h1, 1'b1, 1'b0, 0);
    cycle(4'h1, 1'b1, 1'b1, 0);
    // Release: load on first enabled edge, then hold.
    cycle(4'h1, 1'b1, 1'b0, 0);
    cycle(4'h0, 1'b0, 1'b0, 0);
    cycle(4'h3, 1'b1, 1'b0, 0);
    cycle(4'hF, 1'b0, 1'b1, 0);

    for (int i = 0; i < 400; i++) begin
      cycle(W'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
